// File: rtl/fsm_door_ctrl.sv
// Roll-door controller: motor/light FSM with key edge detection, reversal dead time,
// movement timeout with fault latch. Optional auto-close via `DOOR_AUTO_CLOSE_EN.
module fsm_door_ctrl #(
  parameter int TIMEOUT_CYC    = 40_000_000,
  parameter int DEADTIME_CYC   = 200_000,
  parameter int AUTO_CLOSE_CYC = 60_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       sense_up,
  input  logic       sense_down,
  output logic       ml,
  output logic       mr,
  output logic       light_red,
  output logic       light_green,
  output logic       fault,
  output logic [2:0] db_state
);

  localparam logic [2:0] INIT    = 3'd0;
  localparam logic [2:0] CLOSED  = 3'd1;
  localparam logic [2:0] OPEN    = 3'd2;
  localparam logic [2:0] OPENING = 3'd3;
  localparam logic [2:0] CLOSING = 3'd4;
  localparam logic [2:0] DEAD    = 3'd5;
  localparam logic [2:0] STOP    = 3'd6;
  localparam logic [2:0] FAULT   = 3'd7;

  localparam int MAX_TD  = (TIMEOUT_CYC > DEADTIME_CYC) ? TIMEOUT_CYC : DEADTIME_CYC;
  localparam int MAX_CYC = (MAX_TD > AUTO_CLOSE_CYC) ? MAX_TD : AUTO_CLOSE_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] DEAD_LAST    = TW'(DEADTIME_CYC - 1);
  localparam logic [TW-1:0] DEAD_FULL    = TW'(DEADTIME_CYC);
`ifdef DOOR_AUTO_CLOSE_EN
  localparam logic [TW-1:0] AUTO_LAST    = TW'(AUTO_CLOSE_CYC - 1);
`endif

  logic [2:0]    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          target_close, target_close_nxt;
  logic          key_up_q, key_down_q;
  logic          up_rise, down_rise, both_rise, up_only, down_only;

  assign up_rise   = key_up & ~key_up_q;
  assign down_rise = key_down & ~key_down_q;
  assign both_rise = up_rise & down_rise;
  assign up_only   = up_rise & ~down_rise;
  assign down_only = down_rise & ~up_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= INIT;
      timer        <= '0;
      target_close <= 1'b0;
      key_up_q     <= 1'b0;
      key_down_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      target_close <= target_close_nxt;
      key_up_q     <= key_up;
      key_down_q   <= key_down;
    end
  end

  // The shared timer restarts on every state change; timer expiry outranks key edges.
  always_comb begin
    state_nxt        = state;
    timer_nxt        = timer;
    target_close_nxt = target_close;
    if (sense_up & sense_down) begin
      state_nxt = FAULT;
      timer_nxt = '0;
    end else begin
      case (state)
        INIT: begin
          timer_nxt = '0;
          if (sense_up)        state_nxt = OPEN;
          else if (sense_down) state_nxt = CLOSED;
          else                 state_nxt = STOP;
        end
        CLOSED: begin
          if (both_rise) begin
            state_nxt = STOP;
            timer_nxt = '0;
          end else if (up_only) begin
            state_nxt = OPENING;
            timer_nxt = '0;
          end
        end
        OPEN: begin
          if (both_rise) begin
            state_nxt = STOP;
            timer_nxt = '0;
          end else if (down_only) begin
            state_nxt = CLOSING;
            timer_nxt = '0;
`ifdef DOOR_AUTO_CLOSE_EN
          end else if (up_only) begin
            timer_nxt = '0;
          end else if (timer == AUTO_LAST) begin
            state_nxt = CLOSING;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + 1'b1;
`endif
          end
        end
        OPENING: begin
          timer_nxt = timer + 1'b1;
          if (timer == TIMEOUT_LAST) begin
            state_nxt = FAULT;
            timer_nxt = '0;
          end else if (sense_up) begin
            state_nxt = OPEN;
            timer_nxt = '0;
          end else if (both_rise) begin
            state_nxt = STOP;
            timer_nxt = '0;
          end else if (down_only) begin
            state_nxt        = DEAD;
            timer_nxt        = '0;
            target_close_nxt = 1'b1;
          end
        end
        CLOSING: begin
          timer_nxt = timer + 1'b1;
          if (timer == TIMEOUT_LAST) begin
            state_nxt = FAULT;
            timer_nxt = '0;
          end else if (sense_down) begin
            state_nxt = CLOSED;
            timer_nxt = '0;
          end else if (both_rise) begin
            state_nxt = STOP;
            timer_nxt = '0;
          end else if (up_only) begin
            state_nxt        = DEAD;
            timer_nxt        = '0;
            target_close_nxt = 1'b0;
          end
        end
        DEAD: begin
          timer_nxt = timer + 1'b1;
          if (timer == DEAD_LAST) begin
            state_nxt = target_close ? CLOSING : OPENING;
            timer_nxt = '0;
          end else if (both_rise) begin
            state_nxt = STOP;
            timer_nxt = '0;
          end
        end
        STOP: begin
          // Timer saturates at DEAD_FULL, which marks the lockout as over.
          if (timer != DEAD_FULL) begin
            timer_nxt = timer + 1'b1;
          end else if (up_only) begin
            state_nxt = OPENING;
            timer_nxt = '0;
          end else if (down_only) begin
            state_nxt = CLOSING;
            timer_nxt = '0;
          end
        end
        FAULT: begin
          state_nxt = FAULT;
        end
        default: begin
          state_nxt = FAULT;
          timer_nxt = '0;
        end
      endcase
    end
  end

  assign mr          = (state == OPENING);
  assign ml          = (state == CLOSING);
  assign light_green = (state == OPEN);
  assign light_red   = (state != OPEN);
  assign fault       = (state == FAULT);
  assign db_state    = state;

endmodule

// File: tb/tb_fsm_door_ctrl.sv
// Bench for fsm_door_ctrl: directed scenarios then random keys/sensors, every cycle
// compared against a cycles-in-state reference model of the door behaviour.
module tb_fsm_door_ctrl;

  localparam int TIMEOUT  = 50;
  localparam int DEADTIME = 4;
  localparam int AUTOCL   = 20;

  localparam int S_INIT = 0, S_CLOSED = 1, S_OPEN = 2, S_OPENING = 3;
  localparam int S_CLOSING = 4, S_DEAD = 5, S_STOP = 6, S_FAULT = 7;

  logic       clk = 1'b0;
  logic       rst, key_up, key_down, sense_up, sense_down;
  logic       ml, mr, light_red, light_green, fault;
  logic [2:0] db_state;

  int tests_run = 0;
  int tests_failed = 0;

  int m_st = S_INIT;
  int m_age = 0;
  bit m_tgt_close = 1'b0;
  bit m_upq = 1'b0;
  bit m_dnq = 1'b0;

  fsm_door_ctrl #(
    .TIMEOUT_CYC   (TIMEOUT),
    .DEADTIME_CYC  (DEADTIME),
    .AUTO_CLOSE_CYC(AUTOCL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_up     (key_up),
    .key_down   (key_down),
    .sense_up   (sense_up),
    .sense_down (sense_down),
    .ml         (ml),
    .mr         (mr),
    .light_red  (light_red),
    .light_green(light_green),
    .fault      (fault),
    .db_state   (db_state)
  );

  always #5 clk = ~clk;

  // Reference: door position as a named state plus how many edges it has stayed there.
  task automatic modelStep(input bit r, input bit ku, input bit kd, input bit su, input bit sd);
    bit ur, dr, both, up_only, dn_only, restart;
    int nst;
    if (r) begin
      m_st = S_INIT; m_age = 0; m_upq = 0; m_dnq = 0; m_tgt_close = 0;
      return;
    end
    ur = ku && !m_upq;
    dr = kd && !m_dnq;
    m_upq = ku;
    m_dnq = kd;
    both = ur && dr;
    up_only = ur && !dr;
    dn_only = dr && !ur;
    restart = 0;
    nst = m_st;
    if (su && sd) nst = S_FAULT;
    else begin
      case (m_st)
        S_INIT:   nst = su ? S_OPEN : (sd ? S_CLOSED : S_STOP);
        S_CLOSED: if (both) nst = S_STOP; else if (up_only) nst = S_OPENING;
        S_OPEN: begin
          if (both) nst = S_STOP;
          else if (dn_only) nst = S_CLOSING;
`ifdef DOOR_AUTO_CLOSE_EN
          else if (up_only) restart = 1;
          else if (m_age + 1 >= AUTOCL) nst = S_CLOSING;
`endif
        end
        S_OPENING: begin
          if (m_age + 1 >= TIMEOUT) nst = S_FAULT;
          else if (su) nst = S_OPEN;
          else if (both) nst = S_STOP;
          else if (dn_only) begin nst = S_DEAD; m_tgt_close = 1; end
        end
        S_CLOSING: begin
          if (m_age + 1 >= TIMEOUT) nst = S_FAULT;
          else if (sd) nst = S_CLOSED;
          else if (both) nst = S_STOP;
          else if (up_only) begin nst = S_DEAD; m_tgt_close = 0; end
        end
        S_DEAD: begin
          if (m_age + 1 >= DEADTIME) nst = m_tgt_close ? S_CLOSING : S_OPENING;
          else if (both) nst = S_STOP;
        end
        S_STOP: begin
          if (m_age >= DEADTIME) begin
            if (up_only) nst = S_OPENING;
            else if (dn_only) nst = S_CLOSING;
          end
        end
        default: nst = S_FAULT;
      endcase
    end
    if (nst != m_st || restart) m_age = 0;
    else m_age = m_age + 1;
    m_st = nst;
  endtask

  task automatic checkEq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkEq({tag, ".db_state"}, 8'(db_state), 8'(m_st));
    checkEq({tag, ".mr"}, 8'(mr), 8'(m_st == S_OPENING));
    checkEq({tag, ".ml"}, 8'(ml), 8'(m_st == S_CLOSING));
    checkEq({tag, ".green"}, 8'(light_green), 8'(m_st == S_OPEN));
    checkEq({tag, ".red"}, 8'(light_red), 8'(m_st != S_OPEN));
    checkEq({tag, ".fault"}, 8'(fault), 8'(m_st == S_FAULT));
  endtask

  task automatic applyStimulus(input bit r, input bit ku, input bit kd, input bit su,
                               input bit sd, input string tag);
    rst = r; key_up = ku; key_down = kd; sense_up = su; sense_down = sd;
    modelStep(r, ku, kd, su, sd);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1; key_up = 0; key_down = 0; sense_up = 0; sense_down = 0;
    #1;

    repeat (3) applyStimulus(1, 0, 0, 0, 1, "reset");
    checkEq("reset_state", 8'(db_state), 8'd0);
    checkEq("reset_red", 8'(light_red), 8'd1);
    checkEq("reset_motor", 8'({ml, mr}), 8'd0);
    applyStimulus(0, 0, 0, 0, 1, "init_exit");
    checkEq("closed_state", 8'(db_state), 8'd1);

    applyStimulus(0, 1, 0, 0, 1, "key_up");
    checkEq("opening_mr", 8'(mr), 8'd1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0, 0, "opening_held");
    applyStimulus(0, 0, 0, 1, 0, "sense_up");
    checkEq("open_green", 8'(light_green), 8'd1);
    checkEq("open_red", 8'(light_red), 8'd0);

    applyStimulus(0, 0, 1, 1, 0, "open_key_down");
    applyStimulus(0, 0, 0, 0, 0, "closing");
    applyStimulus(0, 1, 0, 0, 0, "rev_to_dead");
    checkEq("dead_state", 8'(db_state), 8'd5);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, "dead_wait");
    checkEq("dead_motor_off", 8'({ml, mr}), 8'd0);
    applyStimulus(0, 0, 0, 0, 0, "dead_expire");
    checkEq("dead_to_opening", 8'(db_state), 8'd3);

    applyStimulus(0, 0, 1, 0, 0, "rev_to_dead2");
    repeat (4) applyStimulus(0, 0, 0, 0, 0, "dead2");
    checkEq("dead_to_closing_ml", 8'(ml), 8'd1);
    repeat (49) applyStimulus(0, 0, 0, 0, 0, "closing_run");
    checkEq("pre_timeout", 8'(db_state), 8'd4);
    applyStimulus(0, 0, 0, 0, 0, "timeout");
    checkEq("timeout_fault", 8'(fault), 8'd1);
    applyStimulus(0, 1, 0, 0, 0, "fault_key_up");
    applyStimulus(0, 0, 1, 0, 0, "fault_key_down");
    checkEq("fault_sticky", 8'(db_state), 8'd7);

    repeat (2) applyStimulus(1, 0, 0, 0, 0, "reset2");
    applyStimulus(0, 0, 0, 0, 0, "init_to_stop");
    applyStimulus(0, 1, 0, 0, 0, "stop_key_ignored");
    checkEq("stop_lockout", 8'(db_state), 8'd6);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, "stop_wait");
    applyStimulus(0, 1, 0, 0, 0, "stop_key_up");
    checkEq("stop_to_opening", 8'(db_state), 8'd3);
    applyStimulus(0, 0, 0, 0, 0, "release");
    applyStimulus(0, 1, 1, 0, 0, "both_keys");
    checkEq("both_to_stop", 8'(db_state), 8'd6);
    applyStimulus(0, 0, 0, 1, 1, "both_sensors");
    checkEq("sensor_fault", 8'(db_state), 8'd7);

`ifdef DOOR_AUTO_CLOSE_EN
    repeat (2) applyStimulus(1, 0, 0, 1, 0, "reset_ac");
    applyStimulus(0, 0, 0, 1, 0, "init_to_open");
    repeat (19) applyStimulus(0, 0, 0, 1, 0, "open_idle");
    applyStimulus(0, 0, 0, 0, 0, "auto_close");
    checkEq("auto_close_state", 8'(db_state), 8'd4);
    repeat (2) applyStimulus(1, 0, 0, 1, 0, "reset_ac2");
    applyStimulus(0, 0, 0, 1, 0, "init_to_open2");
    repeat (14) applyStimulus(0, 0, 0, 1, 0, "open_idle2");
    applyStimulus(0, 1, 0, 1, 0, "open_key_restart");
    repeat (19) applyStimulus(0, 0, 0, 1, 0, "open_idle3");
    checkEq("auto_close_delayed", 8'(db_state), 8'd2);
    applyStimulus(0, 0, 0, 0, 0, "auto_close2");
    checkEq("auto_close2_state", 8'(db_state), 8'd4);
`endif

    for (int n = 0; n < 3000; n++) begin
      bit r, ku, kd, su, sd;
      r  = ($urandom_range(0, 99) == 0);
      ku = ($urandom_range(0, 7) == 0) ? !key_up : key_up;
      kd = ($urandom_range(0, 7) == 0) ? !key_down : key_down;
      su = ($urandom_range(0, 15) == 0);
      sd = ($urandom_range(0, 15) == 0);
      applyStimulus(r, ku, kd, su, sd, "random");
      tests_run++;
      assert (!(ml && mr)) else begin
        tests_failed++;
        $error("[TB] FAIL motor_exclusive: observed ml=%0b mr=%0b expected not both", ml, mr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
